// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-class LCD write sequencer:
// state encoding, LCD word bit positions, init command ROM and opcodes.
package lcd_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } lcd_state_e;

  localparam int LCD_ON   = 31;
  localparam int LCD_BLON = 30;
  localparam int LCD_EN   = 10;
  localparam int LCD_RS   = 9;
  localparam int LCD_RW   = 8;

  localparam int INIT_LEN = 4;
  // Entry 0 sits in the low byte: function set, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_sequencer.sv
// Byte-level LCD writer: runs the power-on init sequence, then turns each
// accepted command/character into SETUP/PULSE/HOLD/WAIT timing on the LCD word.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int INIT_WAIT_CYC  = 750000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        req_ready_o,
  input  logic        bl_on_i,
  output logic        busy_o,
  output logic        init_done_o,
  output logic [31:0] io_lcd_o
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_CYC), max_int(HOLD_CYC, CMD_WAIT_CYC)),
                                   max_int(max_int(CLEAR_WAIT_CYC, INIT_WAIT_CYC), 1));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(INIT_LEN);

  typedef logic [CNT_W-1:0] cnt_t;

  // A zero-cycle phase is stretched to one cycle.
  function automatic cnt_t phase_load(input int n);
    return (n < 1) ? '0 : cnt_t'(n - 1);
  endfunction

  localparam cnt_t LOAD_SETUP = phase_load(SETUP_CYC);
  localparam cnt_t LOAD_EN    = phase_load(EN_CYC);
  localparam cnt_t LOAD_HOLD  = phase_load(HOLD_CYC);
  localparam cnt_t LOAD_CMD   = phase_load(CMD_WAIT_CYC);
  localparam cnt_t LOAD_CLEAR = phase_load(CLEAR_WAIT_CYC);
  localparam cnt_t LOAD_INIT  = phase_load(INIT_WAIT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  lcd_state_e       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             on_q;
  logic             blon_q;

  cnt_t             cnt_dec;
  logic             phase_done;
  logic [IDX_W-1:0] idx_inc;
  cnt_t             wait_load;

  assign cnt_dec    = cnt_q - cnt_t'(1);
  assign phase_done = (cnt_q == '0);
  assign idx_inc    = idx_q + IDX_W'(1);
  // Clear and home need the long busy time; everything else uses the short one.
  assign wait_load  = (!rs_q && (data_q == CMD_CLEAR || data_q == CMD_HOME)) ? LOAD_CLEAR : LOAD_CMD;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rs_d        = rs_q;
    data_d      = data_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;

    case (state_q)
      RESET_WAIT: begin
        // The power-up delay starts with the first cycle the display is on.
        if (on_q) begin
          if (phase_done) begin
            state_d = SETUP;
            cnt_d   = LOAD_SETUP;
            rs_d    = 1'b0;
            data_d  = INIT_ROM[0];
            idx_d   = '0;
          end else begin
            cnt_d = cnt_dec;
          end
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_d = PULSE;
          cnt_d   = LOAD_EN;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      PULSE: begin
        if (phase_done) begin
          state_d = HOLD;
          cnt_d   = LOAD_HOLD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      HOLD: begin
        if (phase_done) begin
          state_d = WAIT;
          cnt_d   = wait_load;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      WAIT: begin
        if (phase_done) begin
          if (init_done_q) begin
            state_d = IDLE;
          end else if (idx_q == LAST_IDX) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = LOAD_SETUP;
            idx_d   = idx_inc;
            rs_d    = 1'b0;
            data_d  = INIT_ROM[idx_inc];
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d = SETUP;
          cnt_d   = LOAD_SETUP;
          rs_d    = req_rs_i;
          data_d  = req_data_i;
        end
      end
      default: begin
        state_d = RESET_WAIT;
        cnt_d   = LOAD_INIT;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    en_d    = (state_d == PULSE);
    ready_d = (state_d == IDLE) && init_done_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_WAIT;
      cnt_q       <= LOAD_INIT;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      on_q        <= 1'b0;
      blon_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      on_q        <= 1'b1;
      blon_q      <= bl_on_i;
    end
  end

  always_comb begin
    io_lcd_o           = '0;
    io_lcd_o[LCD_ON]   = on_q;
    io_lcd_o[LCD_BLON] = blon_q;
    io_lcd_o[LCD_EN]   = en_q;
    io_lcd_o[LCD_RS]   = rs_q;
    io_lcd_o[LCD_RW]   = 1'b0;
    io_lcd_o[7:0]      = data_q;
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Randomized bench for lcd_write_sequencer: a timeline model derives every
// expected LCD word and handshake flag from each write's start cycle.
module tb_lcd_write_sequencer;

  localparam int S   = 1;
  localparam int E   = 2;
  localparam int H   = 1;
  localparam int CW  = 4;
  localparam int CLW = 8;
  localparam int IW  = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_rs_i = 1'b0;
  logic [7:0]  req_data_i = 8'h00;
  logic        bl_on_i = 1'b0;
  logic        req_ready_o;
  logic        busy_o;
  logic        init_done_o;
  logic [31:0] io_lcd_o;

  always #5 clk = ~clk;

  lcd_write_sequencer #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW), .INIT_WAIT_CYC(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_rs_i(req_rs_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .bl_on_i(bl_on_i), .busy_o(busy_o),
    .init_done_o(init_done_o), .io_lcd_o(io_lcd_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Timeline model: one write at a time, described by its start cycle.
  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  bit         in_rst    = 1'b1;
  int         c1        = 0;
  bit         have_xfer = 1'b0;
  int         x_start   = 0;
  int         x_wait    = 0;
  int         x_idx     = -1;
  bit         x_rs      = 1'b0;
  logic [7:0] x_data    = 8'h00;
  bit         done_m    = 1'b0;
  bit         bl_prev   = 1'b0;
  int         acc_model = 0;
  int         acc_dut   = 0;

  bit          exp_en, exp_ready, exp_busy, exp_done;
  logic [31:0] exp_word;

  always @(posedge clk)
    if (reset_n && req_valid_i && req_ready_o) acc_dut++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, got, want);
    end
  endtask

  function automatic int wait_for(input bit rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLW : CW;
  endfunction

  function automatic int xfer_end();
    return x_start + S + E + H + x_wait;
  endfunction

  task automatic start_xfer(input int at, input bit rs, input logic [7:0] d, input int idx);
    have_xfer = 1'b1;
    x_start   = at;
    x_rs      = rs;
    x_data    = d;
    x_wait    = wait_for(rs, d);
    x_idx     = idx;
  endtask

  task automatic eval_model();
    if (in_rst) begin
      exp_en = 0; exp_ready = 0; exp_busy = 1; exp_done = 0; exp_word = '0;
    end else begin
      if (!have_xfer && cyc == c1 + IW)
        start_xfer(cyc, 1'b0, init_cmds[0], 0);
      else if (have_xfer && x_idx >= 0 && cyc == xfer_end()) begin
        if (x_idx < 3) start_xfer(cyc, 1'b0, init_cmds[x_idx+1], x_idx + 1);
        else begin
          done_m = 1'b1;
          x_idx  = -1;
        end
      end
      exp_en    = have_xfer && (cyc >= x_start + S) && (cyc < x_start + S + E);
      exp_ready = done_m && (cyc >= xfer_end());
      exp_busy  = !exp_ready;
      exp_done  = done_m;
      exp_word  = {1'b1, bl_prev, 19'b0, exp_en, (have_xfer ? x_rs : 1'b0), 1'b0,
                   (have_xfer ? x_data : 8'h00)};
    end
  endtask

  // One cycle: compare at the falling edge, then drive inputs for the next rising edge.
  task automatic tick(input bit v, input bit rs, input logic [7:0] d, input bit bl);
    @(negedge clk);
    cyc++;
    eval_model();
    check("lcd_word", io_lcd_o, exp_word);
    check("ready", 32'(req_ready_o), 32'(exp_ready));
    check("busy", 32'(busy_o), 32'(exp_busy));
    check("init_done", 32'(init_done_o), 32'(exp_done));
    req_valid_i = v;
    req_rs_i    = rs;
    req_data_i  = d;
    bl_on_i     = bl;
    bl_prev     = bl;
    if (!in_rst && exp_ready && v) begin
      start_xfer(cyc + 1, rs, d, -1);
      acc_model++;
      $display("accept cycle %0d rs=%0d data=%h wait=%0d", cyc, rs, d, x_wait);
    end
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    #1;
    check("rst_lcd", io_lcd_o, 32'h0);
    check("rst_done", 32'(init_done_o), 32'h0);
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h1);
    in_rst    = 1'b1;
    have_xfer = 1'b0;
    done_m    = 1'b0;
    x_idx     = -1;
    repeat (n) tick(1'b0, 1'b0, 8'h00, bl_on_i);
    reset_n = 1'b1;
    in_rst  = 1'b0;
    c1      = cyc + 1;
  endtask

  task automatic run_until_ready(input int limit);
    int k = 0;
    while (!exp_ready && k < limit) begin
      tick(1'b0, req_rs_i, req_data_i, bl_on_i);
      k++;
    end
    if (!exp_ready) check("ready_timeout", 32'(req_ready_o), 32'h1);
  endtask

  function automatic logic [7:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 8'h01;
      1:       return 8'h02;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #2;
    apply_reset(3);
    run_until_ready(200);

    tick(1'b1, 1'b1, 8'h41, 1'b1);
    run_until_ready(100);
    tick(1'b1, 1'b0, 8'h01, 1'b1);
    run_until_ready(100);
    tick(1'b1, 1'b0, 8'h02, 1'b0);
    run_until_ready(100);

    // Sparse valids first, then valid held high with data changing every cycle.
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit bl;
      v  = (i < 300) ? ($urandom_range(0, 3) == 0) : 1'b1;
      bl = ($urandom_range(0, 7) == 0) ? ~bl_on_i : bl_on_i;
      tick(v, 1'(($urandom_range(0, 1))), pick_data(), bl);
    end
    tick(1'b0, 1'b0, 8'h00, bl_on_i);

    run_until_ready(100);
    tick(1'b1, 1'b1, 8'h5A, bl_on_i);
    begin
      int k = 0;
      while (!exp_en && k < 20) begin
        tick(1'b0, 1'b0, 8'h00, bl_on_i);
        k++;
      end
    end
    check("en_before_reset", 32'(io_lcd_o[10]), 32'h1);
    apply_reset(2);
    run_until_ready(200);

    for (int i = 0; i < 150; i++) begin
      bit v;
      v = ($urandom_range(0, 1) == 0);
      tick(v, 1'(($urandom_range(0, 1))), pick_data(), 1'(($urandom_range(0, 1))));
    end
    tick(1'b0, 1'b0, 8'h00, bl_on_i);
    tick(1'b0, 1'b0, 8'h00, bl_on_i);
    check("accept_count", 32'(acc_dut), 32'(acc_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
